// File: rtl/vliw_bundle_packer.sv
// vliw_bundle_packer: packs a stream of single 32-bit ops into 10-slot, 320-bit
// VLIW bundles and writes one bundle per EMIT cycle into instruction memory.
// Slot k sits at wr_packet[319-32k -: 32]; unused slots are written as NOP (0).
module vliw_bundle_packer #(
    parameter int          ADDR_W       = 10,
    parameter int unsigned BASE_ADDR    = 0,
    parameter bit          HAZARD_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic              in_last,
    input  logic              flush,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [319:0]      wr_packet,
    output logic              err_illegal
);
    localparam int NSLOT = 10;

    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

    state_t                 state_q, state_d;
    logic [NSLOT-1:0][31:0] slot_q, slot_d;
    logic [NSLOT-1:0]       sv_q, sv_d;
    logic [31:0]            mask_q, mask_d;
    logic [31:0]            pend_q, pend_d;
    logic [NSLOT-1:0]       pend_cand_q, pend_cand_d;
    logic [31:0]            pend_dmask_q, pend_dmask_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   pend_last_q, pend_last_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [319:0]           pkt_q, pkt_d;
    logic                   wr_en_q, wr_en_d;
    logic                   rdy_q, rdy_d;
    logic                   err_q, err_d;

    // Opcode class map: legality, candidate slots, RAW sources and written registers.
    // Register 0 never enters the destination mask, so it can never raise a hazard.
    function automatic void decode(input  logic [31:0]      inst,
                                   output logic             legal,
                                   output logic             nop,
                                   output logic [NSLOT-1:0] cand,
                                   output logic [4:0]       sa,
                                   output logic [4:0]       sb,
                                   output logic [31:0]      dmask);
        legal = 1'b1;
        nop   = 1'b0;
        cand  = '0;
        sa    = '0;
        sb    = '0;
        dmask = '0;
        casez (inst[31:27])
            5'b00000: nop = 1'b1;
            5'b00001, 5'b00010, 5'b00011: begin
                cand = 10'b00_0000_0011;
                sa = inst[21:17]; sb = inst[16:12];
                dmask[inst[26:22]] = 1'b1;
            end
            5'b00100: begin
                cand = 10'b00_0000_0100;
                sa = inst[16:12]; sb = inst[11:7];
                dmask[inst[26:22]] = 1'b1;
                dmask[inst[21:17]] = 1'b1;
            end
            5'b00101: begin
                cand = 10'b00_0001_1000;
                sa = inst[21:17]; sb = inst[16:12];
                dmask[inst[26:22]] = 1'b1;
            end
            5'b00110: begin
                cand = 10'b00_0010_0000;
                sa = inst[16:12]; sb = inst[11:7];
                dmask[inst[26:22]] = 1'b1;
            end
            5'b01???: begin
                cand = 10'b00_0100_0000;
                sa = inst[21:17]; sb = inst[16:12];
                dmask[inst[26:22]] = 1'b1;
            end
            5'b10010: begin
                cand = 10'b00_1000_0000;
                dmask[inst[26:22]] = 1'b1;
            end
            5'b10011: begin
                cand = 10'b01_0000_0000;
                sa = inst[4:0];
            end
            5'b10100: begin
                cand = 10'b10_0000_0000;
                dmask[inst[26:22]] = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        dmask[0] = 1'b0;
    endfunction

    // Lowest-numbered candidate slot that is still free (one-hot, zero if none).
    function automatic logic [NSLOT-1:0] first_free(input logic [NSLOT-1:0] cand,
                                                    input logic [NSLOT-1:0] used);
        logic [NSLOT-1:0] avail;
        avail = cand & ~used;
        return avail & (~avail + 10'd1);
    endfunction

    logic             in_legal, in_nop, in_hazard, in_conflict, in_close;
    logic [NSLOT-1:0] in_cand, in_place, pend_place;
    logic [4:0]       in_sa, in_sb;
    logic [31:0]      in_dmask;

    // Classify the incoming op against the current bundle.
    always_comb begin
        decode(in_inst, in_legal, in_nop, in_cand, in_sa, in_sb, in_dmask);
        in_place    = first_free(in_cand, sv_q);
        in_hazard   = HAZARD_CHECK && (((in_sa != 5'd0) && mask_q[in_sa]) ||
                                       ((in_sb != 5'd0) && mask_q[in_sb]));
        in_conflict = (in_place == '0) || in_hazard;
        in_close    = in_last || flush;
        pend_place  = first_free(pend_cand_q, '0);
    end

    // Next-state: place/park ops while filling, write and recycle on EMIT.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        sv_d         = sv_q;
        mask_d       = mask_q;
        pend_d       = pend_q;
        pend_cand_d  = pend_cand_q;
        pend_dmask_d = pend_dmask_q;
        pend_vld_d   = pend_vld_q;
        pend_last_d  = pend_last_q;
        addr_d       = addr_q;
        pkt_d        = pkt_q;
        err_d        = 1'b0;
        case (state_q)
            EMIT: begin
                addr_d = addr_q + 1'b1;
                slot_d = '0;
                sv_d   = '0;
                mask_d = '0;
                state_d = IDLE;
                if (pend_vld_q) begin
                    // A parked op always fits an empty bundle; seed the new one with it.
                    for (int k = 0; k < NSLOT; k++)
                        if (pend_place[k]) slot_d[k] = pend_q;
                    sv_d       = pend_place;
                    mask_d     = pend_dmask_q;
                    pend_vld_d = 1'b0;
                    state_d    = pend_last_q ? EMIT : FILL;
                end
            end
            default: begin
                if (in_valid && rdy_q) begin
                    if (!in_legal || in_nop) begin
                        err_d = !in_legal;
                        if (in_close && (sv_q != '0)) state_d = EMIT;
                    end else if (in_conflict) begin
                        pend_d       = in_inst;
                        pend_cand_d  = in_cand;
                        pend_dmask_d = in_dmask;
                        pend_last_d  = in_last;
                        pend_vld_d   = 1'b1;
                        state_d      = EMIT;
                    end else begin
                        for (int k = 0; k < NSLOT; k++)
                            if (in_place[k]) slot_d[k] = in_inst;
                        sv_d    = sv_q | in_place;
                        mask_d  = mask_q | in_dmask;
                        state_d = in_close ? EMIT : FILL;
                    end
                end else if (flush && (sv_q != '0)) begin
                    state_d = EMIT;
                end
            end
        endcase
        if (state_d == EMIT)
            for (int k = 0; k < NSLOT; k++) pkt_d[319-32*k -: 32] = slot_d[k];
        wr_en_d = (state_d == EMIT);
        rdy_d   = (state_d != EMIT);
    end

    // State and output registers; reset discards any partial bundle and parked op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            sv_q         <= '0;
            mask_q       <= '0;
            pend_q       <= '0;
            pend_cand_q  <= '0;
            pend_dmask_q <= '0;
            pend_vld_q   <= 1'b0;
            pend_last_q  <= 1'b0;
            addr_q       <= ADDR_W'(BASE_ADDR);
            pkt_q        <= '0;
            wr_en_q      <= 1'b0;
            rdy_q        <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            sv_q         <= sv_d;
            mask_q       <= mask_d;
            pend_q       <= pend_d;
            pend_cand_q  <= pend_cand_d;
            pend_dmask_q <= pend_dmask_d;
            pend_vld_q   <= pend_vld_d;
            pend_last_q  <= pend_last_d;
            addr_q       <= addr_d;
            pkt_q        <= pkt_d;
            wr_en_q      <= wr_en_d;
            rdy_q        <= rdy_d;
            err_q        <= err_d;
        end
    end

    assign in_ready    = rdy_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = addr_q;
    assign wr_packet   = pkt_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_vliw_bundle_packer.sv
// Bench for vliw_bundle_packer: three instances (default, no hazard check, 2-bit
// address) share one input stream; writes are logged and compared with a
// bundle-level reference model plus hand-written expectations.
module tb_vliw_bundle_packer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, flush = 1'b0;
    logic [31:0] in_inst = 32'h0;
    logic        r0, r1, r2, w0, w1, w2, e0, e1, e2;
    logic [9:0]  wa0, wa1;
    logic [1:0]  wa2;
    logic [319:0] p0, p1, p2;

    vliw_bundle_packer #(.ADDR_W(10), .BASE_ADDR(0), .HAZARD_CHECK(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_inst(in_inst),
        .in_last(in_last), .flush(flush), .wr_en(w0), .wr_addr(wa0), .wr_packet(p0), .err_illegal(e0));
    vliw_bundle_packer #(.ADDR_W(10), .BASE_ADDR(0), .HAZARD_CHECK(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_inst(in_inst),
        .in_last(in_last), .flush(flush), .wr_en(w1), .wr_addr(wa1), .wr_packet(p1), .err_illegal(e1));
    vliw_bundle_packer #(.ADDR_W(2), .BASE_ADDR(0), .HAZARD_CHECK(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_inst(in_inst),
        .in_last(in_last), .flush(flush), .wr_en(w2), .wr_addr(wa2), .wr_packet(p2), .err_illegal(e2));

    always #5 clk = ~clk;

    typedef struct { int addr; logic [319:0] pkt; } wr_t;
    typedef struct { logic [31:0] inst; int nwr; int slot; int nerr; } vec_t;

    localparam logic [26:0] BODY = 27'h2A54321;

    int   checks = 0, errors = 0;
    wr_t  act [3][1024];
    int   act_n [3];
    int   err_seen [3];
    int   base [3];
    int   err_base [3];

    // Write/error logger, sampled on the falling edge.
    always @(negedge clk) begin
        if (w0 && act_n[0] < 1024) begin act[0][act_n[0]] = '{int'(wa0), p0}; act_n[0]++; end
        if (w1 && act_n[1] < 1024) begin act[1][act_n[1]] = '{int'(wa1), p1}; act_n[1]++; end
        if (w2 && act_n[2] < 1024) begin act[2][act_n[2]] = '{int'(wa2), p2}; act_n[2]++; end
        if (e0) err_seen[0]++;
        if (e1) err_seen[1]++;
        if (e2) err_seen[2]++;
    end

    // ---------------- reference model (bundle level) ----------------
    logic [31:0] m_slot [3][10];
    bit          m_occ  [3][10];
    logic [31:0] m_dst  [3];
    int          m_addr [3];
    int          m_err;
    wr_t         ex [3][1024];
    int          ex_n [3];

    function automatic logic [319:0] pk(input int k, input logic [31:0] inst);
        logic [319:0] t;
        t = {288'b0, inst};
        return t << (32 * (9 - k));
    endfunction

    function automatic void m_clear(input int v);
        for (int k = 0; k < 10; k++) begin m_slot[v][k] = 32'h0; m_occ[v][k] = 1'b0; end
        m_dst[v] = 32'h0;
    endfunction

    function automatic void m_emit(input int v);
        logic [319:0] p;
        p = '0;
        for (int k = 0; k < 10; k++) if (m_occ[v][k]) p = p | pk(k, m_slot[v][k]);
        if (ex_n[v] < 1024) begin ex[v][ex_n[v]] = '{m_addr[v], p}; ex_n[v]++; end
        m_addr[v] = (m_addr[v] + 1) % ((v == 2) ? 4 : 1024);
        m_clear(v);
    endfunction

    function automatic bit m_empty(input int v);
        for (int k = 0; k < 10; k++) if (m_occ[v][k]) return 1'b0;
        return 1'b1;
    endfunction

    // kind: 0 nop, 1 legal, 2 illegal; register 0 stands for "no operand".
    function automatic void m_class(input logic [31:0] x, output int kind, output int c0, output int c1,
                                    output int sa, output int sb, output int da, output int db);
        int op;
        op = int'(x[31:27]);
        kind = 1; c0 = -1; c1 = -1; sa = 0; sb = 0; da = 0; db = 0;
        if (op == 0) kind = 0;
        else if (op >= 1 && op <= 3) begin c0 = 0; c1 = 1; sa = int'(x[21:17]); sb = int'(x[16:12]); da = int'(x[26:22]); end
        else if (op == 4) begin c0 = 2; sa = int'(x[16:12]); sb = int'(x[11:7]); da = int'(x[26:22]); db = int'(x[21:17]); end
        else if (op == 5) begin c0 = 3; c1 = 4; sa = int'(x[21:17]); sb = int'(x[16:12]); da = int'(x[26:22]); end
        else if (op == 6) begin c0 = 5; sa = int'(x[16:12]); sb = int'(x[11:7]); da = int'(x[26:22]); end
        else if (op >= 8 && op <= 15) begin c0 = 6; sa = int'(x[21:17]); sb = int'(x[16:12]); da = int'(x[26:22]); end
        else if (op == 18) begin c0 = 7; da = int'(x[26:22]); end
        else if (op == 19) begin c0 = 8; sa = int'(x[4:0]); end
        else if (op == 20) begin c0 = 9; da = int'(x[26:22]); end
        else kind = 2;
    endfunction

    function automatic void m_put(input int v, input int k, input logic [31:0] x, input int da, input int db);
        m_slot[v][k] = x;
        m_occ[v][k]  = 1'b1;
        if (da != 0) m_dst[v][da] = 1'b1;
        if (db != 0) m_dst[v][db] = 1'b1;
    endfunction

    function automatic void m_op(input int v, input logic [31:0] x, input logic last, input logic fl);
        int kind, c0, c1, sa, sb, da, db, slot;
        bit hz, empty;
        m_class(x, kind, c0, c1, sa, sb, da, db);
        empty = m_empty(v);
        if (kind != 1) begin
            if (kind == 2 && v == 0) m_err++;
            if ((last || fl) && !empty) m_emit(v);
            return;
        end
        slot = -1;
        if (!m_occ[v][c0]) slot = c0;
        else if (c1 >= 0 && !m_occ[v][c1]) slot = c1;
        hz = (v != 1) && ((sa != 0 && m_dst[v][sa]) || (sb != 0 && m_dst[v][sb]));
        if (slot < 0 || hz) begin
            m_emit(v);
            m_put(v, c0, x, da, db);
            if (last) m_emit(v);
        end else begin
            m_put(v, slot, x, da, db);
            if (last || fl) m_emit(v);
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [319:0] a, input logic [319:0] e);
        checks++;
        if (a !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, a, e); end
    endtask

    task automatic chki(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin errors++; $display("FAIL %s: got %0d want %0d", nm, a, e); end
    endtask

    function automatic wr_t got(input int v, input int i);
        return act[v][base[v] + i];
    endfunction

    task automatic do_reset();
        in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; in_inst = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int v = 0; v < 3; v++) begin
            base[v] = act_n[v]; err_base[v] = err_seen[v];
            ex_n[v] = 0; m_addr[v] = 0; m_clear(v);
        end
        m_err = 0;
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (!(r0 && r1 && r2)) begin
            if (n == 50) begin
                checks++; errors++;
                $display("FAIL ready_timeout: in_ready low for %0d cycles, want 1", n);
                return;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic send(input logic [31:0] x, input logic last, input logic fl);
        wait_rdy();
        in_valid = 1'b1; in_inst = x; in_last = last; flush = fl;
        @(posedge clk); #1;
        in_valid = 1'b0; in_inst = 32'h0; in_last = 1'b0; flush = 1'b0;
        for (int v = 0; v < 3; v++) m_op(v, x, last, fl);
    endtask

    task automatic send_flush();
        wait_rdy();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int v = 0; v < 3; v++) if (!m_empty(v)) m_emit(v);
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        for (int v = 0; v < 3; v++) begin
            int n;
            n = act_n[v] - base[v];
            chki($sformatf("%s_count_%0d", tag, v), n, ex_n[v]);
            chki($sformatf("%s_err_%0d", tag, v), err_seen[v] - err_base[v], m_err);
            for (int i = 0; i < n && i < ex_n[v]; i++) begin
                wr_t g;
                g = got(v, i);
                chki($sformatf("%s_addr_%0d_%0d", tag, v, i), g.addr, ex[v][i].addr);
                chk($sformatf("%s_pkt_%0d_%0d", tag, v, i), g.pkt, ex[v][i].pkt);
            end
        end
    endtask

    logic [4:0] op_pool [16];

    function automatic logic [31:0] rand_inst();
        logic [31:0] b;
        b = $urandom & ~(32'h0600_0000 | 32'h0030_0000 | 32'h0001_8000 | 32'h0000_0C00 | 32'h0000_0018);
        return {op_pool[$urandom_range(0, 15)], b[26:0]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tv [15];
        logic [31:0] a1, a2, a3, mul, lg, bad;

        op_pool = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd13,
                    5'd18, 5'd19, 5'd20, 5'd0, 5'd7, 5'd31, 5'd1, 5'd5};
        tv[0]  = '{{5'd1,  BODY}, 1, 0, 0};
        tv[1]  = '{{5'd3,  BODY}, 1, 0, 0};
        tv[2]  = '{{5'd4,  BODY}, 1, 2, 0};
        tv[3]  = '{{5'd5,  BODY}, 1, 3, 0};
        tv[4]  = '{{5'd6,  BODY}, 1, 5, 0};
        tv[5]  = '{{5'd8,  BODY}, 1, 6, 0};
        tv[6]  = '{{5'd15, BODY}, 1, 6, 0};
        tv[7]  = '{{5'd18, BODY}, 1, 7, 0};
        tv[8]  = '{{5'd19, BODY}, 1, 8, 0};
        tv[9]  = '{{5'd20, BODY}, 1, 9, 0};
        tv[10] = '{{5'd0,  BODY}, 0, 0, 0};
        tv[11] = '{{5'd7,  BODY}, 0, 0, 1};
        tv[12] = '{{5'd31, BODY}, 0, 0, 1};
        tv[13] = '{{5'd16, BODY}, 0, 0, 1};
        tv[14] = '{{5'd2,  BODY}, 1, 0, 0};

        // Reset state
        do_reset();
        chki("rst_wr_en", int'(w0), 0);
        chki("rst_wr_addr", int'(wa0), 0);
        chk("rst_wr_packet", p0, '0);
        chki("rst_err", int'(e0), 0);
        chki("rst_ready", int'(r0), 1);

        // Class map: one op with in_last from an empty bundle
        for (int i = 0; i < 15; i++) begin
            do_reset();
            send(tv[i].inst, 1'b1, 1'b0);
            drain(3);
            chki($sformatf("vec%0d_writes", i), act_n[0] - base[0], tv[i].nwr);
            chki($sformatf("vec%0d_err", i), err_seen[0] - err_base[0], tv[i].nerr);
            if (tv[i].nwr == 1) begin
                chki($sformatf("vec%0d_addr", i), got(0, 0).addr, 0);
                chk($sformatf("vec%0d_pkt", i), got(0, 0).pkt, pk(tv[i].slot, tv[i].inst));
            end
        end

        // Two ADDs and a MUL close one bundle; check write latency
        do_reset();
        a1  = {5'd1, 5'd3, 5'd1, 5'd2, 12'd0};
        a2  = {5'd1, 5'd4, 5'd1, 5'd1, 12'd0};
        mul = {5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 7'd0};
        send(a1, 1'b0, 1'b0);
        send(a2, 1'b0, 1'b0);
        send(mul, 1'b1, 1'b0);
        chki("t1_wr_en_now", int'(w0), 1);
        chki("t1_ready_emit", int'(r0), 0);
        @(posedge clk); #1;
        chki("t1_wr_en_one_cycle", int'(w0), 0);
        drain(3);
        chki("t1_writes", act_n[0] - base[0], 1);
        chki("t1_addr", got(0, 0).addr, 0);
        chk("t1_pkt", got(0, 0).pkt, pk(0, a1) | pk(1, a2) | pk(2, mul));

        // Third ADD has no free slot and opens the next bundle
        do_reset();
        a3 = {5'd1, 5'd5, 5'd1, 5'd2, 12'd0};
        send(a1, 1'b0, 1'b0);
        send(a2, 1'b0, 1'b0);
        send(a3, 1'b0, 1'b0);
        send_flush();
        drain(4);
        chki("t2_writes", act_n[0] - base[0], 2);
        chki("t2_addr0", got(0, 0).addr, 0);
        chk("t2_pkt0", got(0, 0).pkt, pk(0, a1) | pk(1, a2));
        chki("t2_addr1", got(0, 1).addr, 1);
        chk("t2_pkt1", got(0, 1).pkt, pk(0, a3));

        // RAW dependency splits the bundle only when hazard checking is on
        do_reset();
        lg = {5'b01000, 5'd9, 5'd3, 5'd4, 12'd0};
        send(a1, 1'b0, 1'b0);
        send(lg, 1'b0, 1'b0);
        send_flush();
        drain(4);
        chki("t3_hc_writes", act_n[0] - base[0], 2);
        chk("t3_hc_pkt0", got(0, 0).pkt, pk(0, a1));
        chki("t3_hc_addr1", got(0, 1).addr, 1);
        chk("t3_hc_pkt1", got(0, 1).pkt, pk(6, lg));
        chki("t3_nohc_writes", act_n[1] - base[1], 1);
        chk("t3_nohc_pkt", got(1, 0).pkt, pk(0, a1) | pk(6, lg));

        // Illegal op between two ADDs is dropped with one error pulse
        do_reset();
        bad = {5'b11111, 27'd0};
        send(a1, 1'b0, 1'b0);
        send(bad, 1'b0, 1'b0);
        send(a2, 1'b0, 1'b0);
        send_flush();
        drain(4);
        chki("t4_err", err_seen[0] - err_base[0], 1);
        chki("t4_writes", act_n[0] - base[0], 1);
        chk("t4_pkt", got(0, 0).pkt, pk(0, a1) | pk(1, a2));

        // Address wrap on the 2-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) send({5'd20, 5'(i + 1), 22'd0}, 1'b1, 1'b0);
        drain(4);
        chki("t5_writes", act_n[2] - base[2], 5);
        for (int i = 0; i < 5; i++) chki($sformatf("t5_addr%0d", i), got(2, i).addr, i % 4);
        chk("t5_pkt4", got(2, 4).pkt, pk(9, {5'd20, 5'd5, 22'd0}));

        // Reset mid-bundle discards it without a write
        do_reset();
        send(a1, 1'b0, 1'b0);
        send(a2, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        for (int v = 0; v < 3; v++) m_clear(v);
        send_flush();
        drain(4);
        chki("t6_writes", act_n[0] - base[0], 0);
        chki("t6_addr", int'(wa0), 0);
        chki("t6_ready", int'(r0), 1);

        // Randomized stream against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) send_flush();
            else if (r == 1) begin @(posedge clk); #1; end
            else send(rand_inst(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end
        send_flush();
        drain(6);
        cmp_model("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
